// File: rtl/dpa_tx_seq.sv
// DPA transmit link-training sequencer: IDLE -> TRAIN -> GUARD -> DATA, driving the ODDR d1/d2 words.
// Optional automatic retrain from DATA is built when DPA_TX_SEQ_RETRAIN_EN is defined.
module dpa_tx_seq #(
  parameter int          TRAIN_CYCLES     = 1024,
  parameter int          GUARD_CYCLES     = 16,
  parameter logic [4:0]  IDLE_D1          = 5'b00000,
  parameter logic [4:0]  IDLE_D2          = 5'b00000,
  parameter int          RETRAIN_INTERVAL = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] pat,
  output logic       pat_en,
  input  logic [4:0] s_d1,
  input  logic [4:0] s_d2,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [4:0] tx_d1,
  output logic [4:0] tx_d2,
  output logic       train_active,
  output logic       link_up,
  output logic       train_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRAIN = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_DATA  = 2'd3;

  localparam int MAX_CYCLES = (TRAIN_CYCLES > GUARD_CYCLES) ? TRAIN_CYCLES : GUARD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          enter_data;
  logic          retrain_hit;

`ifdef DPA_TX_SEQ_RETRAIN_EN
  localparam int RW = $clog2(RETRAIN_INTERVAL + 1);

  logic [RW-1:0] rcnt;

  // Counts DATA cycles; held at zero outside DATA so every DATA entry starts fresh.
  assign retrain_hit = (state == ST_DATA) && (rcnt == RW'(RETRAIN_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (state != ST_DATA) begin
      rcnt <= '0;
    end else if (!retrain_hit) begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  logic unused_retrain_interval;

  assign unused_retrain_interval = |RETRAIN_INTERVAL;
  assign retrain_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_data = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_TRAIN;
          cnt_nxt   = CW'(TRAIN_CYCLES);
        end
      end
      ST_TRAIN: begin
        if (cnt == CW'(1)) begin
          state_nxt = ST_GUARD;
          cnt_nxt   = CW'(GUARD_CYCLES);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_GUARD: begin
        if (cnt == CW'(1)) begin
          state_nxt  = ST_DATA;
          cnt_nxt    = '0;
          enter_data = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_DATA: begin
        if (start || retrain_hit) begin
          state_nxt = ST_TRAIN;
          cnt_nxt   = CW'(TRAIN_CYCLES);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      enter_data = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      train_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      train_done <= enter_data;
    end
  end

  // Output words are selected from the current state and registered once toward the ODDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_d1 <= IDLE_D1;
      tx_d2 <= IDLE_D2;
    end else if (state == ST_TRAIN) begin
      tx_d1 <= {5{pat[1]}};
      tx_d2 <= {5{pat[0]}};
    end else if ((state == ST_DATA) && s_valid) begin
      tx_d1 <= s_d1;
      tx_d2 <= s_d2;
    end else begin
      tx_d1 <= IDLE_D1;
      tx_d2 <= IDLE_D2;
    end
  end

  assign pat_en       = (state == ST_TRAIN);
  assign s_ready      = (state == ST_DATA);
  assign link_up      = (state == ST_DATA);
  assign train_active = (state == ST_TRAIN) || (state == ST_GUARD);

endmodule

// File: tb/tb_dpa_tx_seq.sv
// Self-checking bench for dpa_tx_seq: directed control sequence with random data against a timeline model.
// Exercises the DPA_TX_SEQ_RETRAIN_EN build as well when that macro is defined.
module tb_dpa_tx_seq;

  localparam int         T  = 8;
  localparam int         G  = 4;
  localparam int         RI = 20;
  localparam logic [4:0] I1 = 5'h03;
  localparam logic [4:0] I2 = 5'h1C;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] pat;
  logic       pat_en;
  logic [4:0] s_d1;
  logic [4:0] s_d2;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] tx_d1;
  logic [4:0] tx_d2;
  logic       train_active;
  logic       link_up;
  logic       train_done;

  int vectors;
  int miscompares;

  // Model: pos is cycles since the current training sequence began, -1 when idle.
  int         pos;
  logic [4:0] exp_tx1;
  logic [4:0] exp_tx2;

  dpa_tx_seq #(
    .TRAIN_CYCLES    (T),
    .GUARD_CYCLES    (G),
    .IDLE_D1         (I1),
    .IDLE_D2         (I2),
    .RETRAIN_INTERVAL(RI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .pat         (pat),
    .pat_en      (pat_en),
    .s_d1        (s_d1),
    .s_d2        (s_d2),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .tx_d1       (tx_d1),
    .tx_d2       (tx_d2),
    .train_active(train_active),
    .link_up     (link_up),
    .train_done  (train_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_one(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (pos %0d, t=%0t)", tag, obs, exp, pos, $time);
    end
  endtask

  task automatic checkOutput();
    bit in_train, in_guard, in_data;
    in_train = (pos >= 0) && (pos < T);
    in_guard = (pos >= T) && (pos < T + G);
    in_data  = (pos >= T + G);
    check_one("pat_en",       {4'b0, pat_en},       {4'b0, in_train});
    check_one("s_ready",      {4'b0, s_ready},      {4'b0, in_data});
    check_one("train_active", {4'b0, train_active}, {4'b0, in_train | in_guard});
    check_one("link_up",      {4'b0, link_up},      {4'b0, in_data});
    check_one("train_done",   {4'b0, train_done},   {4'b0, pos == T + G});
    check_one("tx_d1",        tx_d1,                exp_tx1);
    check_one("tx_d2",        tx_d2,                exp_tx2);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit in_train, in_data, auto_retrain;
    in_train     = (pos >= 0) && (pos < T);
    in_data      = (pos >= T + G);
    auto_retrain = 1'b0;
`ifdef DPA_TX_SEQ_RETRAIN_EN
    auto_retrain = in_data && ((pos - (T + G) + 1) == RI);
`endif
    if (in_train) begin
      exp_tx1 = {5{pat[1]}};
      exp_tx2 = {5{pat[0]}};
    end else if (in_data && s_valid) begin
      exp_tx1 = s_d1;
      exp_tx2 = s_d2;
    end else begin
      exp_tx1 = I1;
      exp_tx2 = I2;
    end
    if (abort)                               pos = -1;
    else if (pos < 0)                        pos = start ? 0 : -1;
    else if (in_data && (start || auto_retrain)) pos = 0;
    else                                     pos = pos + 1;
  endtask

  // mode 0: s_valid low, 1: toggling 5'h15/5'h0A stream, 2: fully random
  task automatic applyStimulus(input bit st, input bit ab, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput();
      start = (i == 0) ? st : 1'b0;
      abort = (i == 0) ? ab : 1'b0;
      pat   = 2'($urandom);
      if (mode == 1) begin
        s_valid = ~s_valid;
        s_d1    = 5'h15;
        s_d2    = 5'h0A;
      end else begin
        s_valid = (mode == 2) ? 1'($urandom) : 1'b0;
        s_d1    = 5'($urandom);
        s_d2    = 5'($urandom);
      end
      model_step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pos         = -1;
    exp_tx1     = I1;
    exp_tx2     = I2;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    pat         = 2'b00;
    s_d1        = 5'h00;
    s_d2        = 5'h00;
    s_valid     = 1'b0;

    repeat (2) begin
      @(negedge clk);
      checkOutput();
    end
    rst_n = 1'b1;

    // First sequence; second start lands in GUARD and must be ignored.
    applyStimulus(1'b0, 1'b0, 9, 2);
    applyStimulus(1'b1, 1'b0, 10, 2);
    applyStimulus(1'b1, 1'b0, 1, 2);
    applyStimulus(1'b0, 1'b0, 16, 1);

    // Manual retrain from DATA, full sequence back into DATA.
    applyStimulus(1'b1, 1'b0, 20, 1);

    // Retrain then abort in the third TRAIN cycle.
    applyStimulus(1'b1, 1'b0, 3, 2);
    applyStimulus(1'b0, 1'b1, 4, 2);

    // Abort together with start from IDLE.
    applyStimulus(1'b1, 1'b1, 4, 2);

    // Long DATA hold (auto-retrains only in the retrain build).
    applyStimulus(1'b1, 1'b0, 12, 0);
    applyStimulus(1'b0, 1'b0, 110, 2);

    // Asynchronous reset mid-DATA, checked between edges.
    applyStimulus(1'b1, 1'b0, 14, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    pos     = -1;
    exp_tx1 = I1;
    exp_tx2 = I2;
    checkOutput();
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 2, 2);
    applyStimulus(1'b1, 1'b0, 16, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpa_tx_seq.md
# dpa_tx_seq

Link-training sequencer for the DPA transmit path. It sits between the DPA pattern generator, the user transmit stream and the 5-channel DDR output stage (4 data lanes plus ctl). On request it runs a timed training burst from the pattern generator, then a guard gap of idle words, then opens the link to user data. It owns the `enable` of the pattern generator and the `d1`/`d2` inputs of the data ODDR.

## Interface
Parameters:
- `TRAIN_CYCLES`, 1024: cycles with the pattern generator enabled per training burst (≥1).
- `GUARD_CYCLES`, 16: idle-word cycles between training and data (≥1).
- `IDLE_D1`, 5'b00000: rising-edge word sent when idle.
- `IDLE_D2`, 5'b00000: falling-edge word sent when idle.
- `RETRAIN_INTERVAL`, 1000000: DATA-state cycles before automatic retrain. Used only with `DPA_TX_SEQ_RETRAIN_EN`.

Ports:
- `clk`  in  1  125 MHz transmit clock, same clock as the data ODDR.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse that requests training.
- `abort`  in  1  pulse that forces IDLE.
- `pat`  in  2  pattern generator output, `{d1_bit, d2_bit}`.
- `pat_en`  out  1  pattern generator enable.
- `s_d1`  in  5  user rising-edge word `{ctl, txd[3:0]}`.
- `s_d2`  in  5  user falling-edge word.
- `s_valid`  in  1  user word valid.
- `s_ready`  out  1  user word accepted when `s_valid & s_ready`.
- `tx_d1`  out  5  to ODDR `d1`.
- `tx_d2`  out  5  to ODDR `d2`.
- `train_active`  out  1  high in TRAIN or GUARD.
- `link_up`  out  1  high in DATA.
- `train_done`  out  1  one-cycle pulse on entry to DATA.

## Operation
States and transitions:
- IDLE: goes to TRAIN on `start`.
- TRAIN: lasts `TRAIN_CYCLES` cycles, then GUARD.
- GUARD: lasts `GUARD_CYCLES` cycles, then DATA.
- DATA: goes to TRAIN on `start` (manual retrain).

Rules that apply in every state:
- `abort` sends the FSM to IDLE on the next edge from any state. If `abort` and `start` arrive together, `abort` wins.
- `start` is ignored in TRAIN and GUARD.

Counters:
- A single down-counter, width `$clog2(max(TRAIN_CYCLES,GUARD_CYCLES)+1)`.
- It is loaded on each state entry and the state exits when it reaches 1. Each state therefore lasts exactly N cycles.

Output selection (registered):
- TRAIN: `tx_d1={5{pat[1]}}`, `tx_d2={5{pat[0]}}`.
- DATA with `s_valid` high: `tx_d1=s_d1`, `tx_d2=s_d2`.
- All other cases: `IDLE_D1` / `IDLE_D2`.

Combinational outputs:
- `pat_en` = 1 exactly while in TRAIN.
- `s_ready` = 1 exactly while in DATA.
- `train_active` and `link_up` are decoded from the state.
- `train_done` is registered.

## Timing
- Reset values: state IDLE, `pat_en`=0, `s_ready`=0, `train_active`=0, `link_up`=0, `train_done`=0, `tx_d1`=`IDLE_D1`, `tx_d2`=`IDLE_D2`, counters 0.
- `start` sampled at edge k: TRAIN from cycle k+1, so `pat_en` is high in cycles k+1 … k+TRAIN_CYCLES.
- `pat` is taken combinationally in the same cycle and appears on `tx_*` one cycle later.
- GUARD occupies cycles k+TRAIN_CYCLES+1 … k+TRAIN_CYCLES+GUARD_CYCLES.
- DATA starts at k+TRAIN_CYCLES+GUARD_CYCLES+1. `link_up` and `s_ready` rise in that cycle, and `train_done` pulses in the same cycle.
- User data latency: a word accepted at edge j is on `tx_*` after edge j (one register stage).
- The last TRAIN `pat` sample appears on `tx_*` in the first GUARD cycle.
- On `abort` or a DATA→TRAIN retrain, `s_ready` drops in the next cycle, and a word presented in that cycle is not accepted. No partial word is possible because words are atomic.
- Asserting `rst_n` mid-operation returns all outputs to their reset values immediately (asynchronously).

## Configuration
- `DPA_TX_SEQ_RETRAIN_EN` defined:
  - A `$clog2(RETRAIN_INTERVAL+1)`-bit counter runs only in DATA and clears on DATA entry.
  - When it reaches `RETRAIN_INTERVAL` cycles, the FSM goes to TRAIN, exactly as for `start`.
  - `abort` still has priority.
- `DPA_TX_SEQ_RETRAIN_EN` undefined: the counter is not built, `RETRAIN_INTERVAL` is ignored, and DATA is left only by `start` or `abort`.

## Test plan
- Reset, then set TRAIN_CYCLES=8, GUARD_CYCLES=4 and pulse `start` at cycle 10.
  - Required: `pat_en` high for cycles 11–18.
  - Required: `tx_*` shows `{5{pat[1]}}`/`{5{pat[0]}}` for cycles 12–19.
  - Required: idle words for cycles 20–22.
  - Required: `link_up` and a `train_done` pulse at cycle 23.
- In DATA, stream 5'h15/5'h0A with `s_valid` toggling.
  - Required: each accepted word appears one cycle later.
  - Required: idle words in cycles where `s_valid` is low.
- `abort` at the 3rd TRAIN cycle, and separately together with `start` in IDLE.
  - Required: IDLE in the next cycle, `pat_en`=0, and no training in either case.
- `start` pulsed again mid-GUARD, then mid-DATA.
  - Required: mid-GUARD pulse is ignored.
  - Required: mid-DATA pulse drops `s_ready` next cycle and runs a new 8+4 sequence.
- Drop `rst_n` asynchronously mid-DATA, between clock edges.
  - Required: all outputs at reset values before the next edge.
- With `DPA_TX_SEQ_RETRAIN_EN` and RETRAIN_INTERVAL=20: after 20 DATA cycles TRAIN re-enters automatically.
- Without `DPA_TX_SEQ_RETRAIN_EN`: DATA holds for more than 100 cycles.
